// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and output patterns for the pipeline hazard/stall controller.
// Imported by the controller top and its load-use compare.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN,
    MUL_BUSY
  } state_t;

  localparam logic [3:0] REG_ZERO = 4'd0;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF = '0;

  localparam ctrl_t CTRL_RUN = '{
    pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
    exmem_we: 1'b1, memwb_we: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0,
    exmem_flush: 1'b0
  };

  // Flushed buffers keep we=1; the flush wins at the buffer.
  localparam ctrl_t CTRL_BRANCH = '{
    pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
    exmem_we: 1'b1, memwb_we: 1'b1,
    ifid_flush: 1'b1, idex_flush: 1'b1,
    exmem_flush: 1'b0
  };

  localparam ctrl_t CTRL_MUL_STALL = '{
    pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0,
    exmem_we: 1'b1, memwb_we: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0,
    exmem_flush: 1'b1
  };

  localparam ctrl_t CTRL_LOAD_USE = '{
    pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b1,
    exmem_we: 1'b1, memwb_we: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b1,
    exmem_flush: 1'b0
  };

endpackage

// File: rtl/pipe_stall_ctrl_load_use_detect.sv
// Load-use hazard compare: ID source registers against the EX load target.
// r0 is never a real dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  output logic              hazard
);

  logic rd_live;
  logic hit1;
  logic hit2;

  assign rd_live = ex_is_load
                && (ex_rd != REG_AW'(REG_ZERO));
  assign hit1 = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit2 = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard = rd_live && (hit1 || hit2);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central hazard controller: load-use stall, multi-cycle multiply
// stall and taken-branch flush for the 5-stage pipeline.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_is_mul,
  input  logic              ex_branch_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              exmem_we,
  output logic              memwb_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [PERF_W-1:0] stall_cycles
);

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  ctrl_t      ctrl;
  logic       lu_hazard;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_lud (
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .ex_rd     (ex_rd),
    .ex_is_load(ex_is_load),
    .hazard    (lu_hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    ctrl    = CTRL_RUN;
    state_n = state;
    cnt_n   = cnt;
    if (rst) begin
      ctrl    = CTRL_OFF;
      state_n = RUN;
      cnt_n   = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_branch_taken) begin
            ctrl = CTRL_BRANCH;
          end else if (ex_is_mul) begin
            ctrl    = CTRL_MUL_STALL;
            cnt_n   = 4'(MUL_CYCLES - 2);
            state_n = MUL_BUSY;
          end else if (lu_hazard) begin
            ctrl = CTRL_LOAD_USE;
          end
        end
        MUL_BUSY: begin
          // cnt==0 is the release cycle: result drops into EX/MEM.
          if (cnt != 4'd0) begin
            ctrl  = CTRL_MUL_STALL;
            cnt_n = cnt - 4'd1;
          end else begin
            state_n = RUN;
          end
        end
        default: begin
          state_n = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!ctrl.pc_we && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign idex_we     = ctrl.idex_we;
  assign exmem_we    = ctrl.exmem_we;
  assign memwb_we    = ctrl.memwb_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;

endmodule
